// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg: shared types and constants for the Mandelbrot iteration engine.
//   state_e  : engine FSM states (IDLE, RUN, DONE)
//   FP_ONE   : 1.0 in the default 2.(WIDTH-2) fixed-point format (WIDTH = 8)
//   is_pow2  : power-of-two test, used to schedule periodicity snapshots
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MB_WIDTH = 8;
  localparam int FP_ONE   = 1 << (MB_WIDTH - 2);

  function automatic logic is_pow2(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/mandelbrot_alu.sv
// mandelbrot_alu: combinational single step z' = z^2 + c in signed 2.(WIDTH-2).
//   zr, zi     in  current z
//   cr, ci     in  point c
//   out_zr/zi  out next z (truncated toward -inf after each product)
//   size       out |z|^2 of the *current* z exceeds 4.0 (escape radius 2)
//   overflow   out next z does not fit in WIDTH signed bits
module mandelbrot_alu #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  output logic signed [WIDTH-1:0] out_zr,
  output logic signed [WIDTH-1:0] out_zi,
  output logic                    size,
  output logic                    overflow
);
  localparam int FRAC = WIDTH - 2;
  // Headroom: |z|^2 reaches 2^(2W-1), which needs 2W+1 signed bits.
  localparam int PW   = 2 * WIDTH + 2;
  localparam logic [PW-1:0] ESC_R2 = {{(PW-1){1'b0}}, 1'b1} << (2 * WIDTH - 2);

  logic signed [PW-1:0] w_zrx, w_zix, w_crx, w_cix;
  logic signed [PW-1:0] w_re, w_im, w_mag;

  assign w_zrx = {{(PW-WIDTH){zr[WIDTH-1]}}, zr};
  assign w_zix = {{(PW-WIDTH){zi[WIDTH-1]}}, zi};
  assign w_crx = {{(PW-WIDTH){cr[WIDTH-1]}}, cr};
  assign w_cix = {{(PW-WIDTH){ci[WIDTH-1]}}, ci};

  assign w_re  = ((w_zrx * w_zrx - w_zix * w_zix) >>> FRAC) + w_crx;
  // 2*zr*zi folded into a shift one less than FRAC
  assign w_im  = ((w_zrx * w_zix) >>> (FRAC - 1)) + w_cix;
  assign w_mag = w_zrx * w_zrx + w_zix * w_zix;

  assign out_zr   = w_re[WIDTH-1:0];
  assign out_zi   = w_im[WIDTH-1:0];
  assign size     = $unsigned(w_mag) > ESC_R2;
  // Fits iff the bits above the result sign are a pure sign extension.
  assign overflow = ((|w_re[PW-1:WIDTH-1]) & ~(&w_re[PW-1:WIDTH-1])) |
                    ((|w_im[PW-1:WIDTH-1]) & ~(&w_im[PW-1:WIDTH-1]));

endmodule

// File: rtl/mandelbrot_iter_ctrl.sv
// mandelbrot_iter_ctrl: sequential Mandelbrot iteration engine for one pixel.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     accept c = (in_cr, in_ci) and max_iter (IDLE only)
//   out_valid/out_ready   result handshake (DONE only)
//   out_iter, out_escaped iterations completed before escape (or max_iter), escape flag
// Optional build macro MANDELBROT_CYCLE_DETECT_EN adds Brent-style periodicity
// detection so interior points finish early with out_iter = max_iter.
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_cr,
  input  logic signed [WIDTH-1:0] in_ci,
  input  logic [ITER_WIDTH-1:0]   max_iter,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ITER_WIDTH-1:0]   out_iter,
  output logic                    out_escaped
);

  state_e r_state, w_state_nxt;

  logic signed [WIDTH-1:0] r_zr, r_zi, r_cr, r_ci;
  logic signed [WIDTH-1:0] w_alu_zr, w_alu_zi;
  logic                    w_alu_size, w_alu_ovf, w_escape;
  logic [ITER_WIDTH-1:0]   r_iter, r_max, r_out_iter, w_iter_nxt, w_out_iter_d;
  logic                    r_out_esc, w_out_esc_d;
  logic                    w_accept, w_step, w_load_out, w_cycle_hit;

  mandelbrot_alu #(.WIDTH(WIDTH)) u_alu (
    .zr       (r_zr),
    .zi       (r_zi),
    .cr       (r_cr),
    .ci       (r_ci),
    .out_zr   (w_alu_zr),
    .out_zi   (w_alu_zi),
    .size     (w_alu_size),
    .overflow (w_alu_ovf)
  );

  assign w_escape   = w_alu_size | w_alu_ovf;
  // r_iter < r_max <= 2^ITER_WIDTH-1 while running, so this never wraps.
  assign w_iter_nxt = r_iter + 1'b1;

`ifdef MANDELBROT_CYCLE_DETECT_EN
  logic signed [WIDTH-1:0] r_sr, r_si;
  logic                    w_snap;

  // Compare against the snapshot before it is refreshed this cycle.
  assign w_cycle_hit = (w_alu_zr == r_sr) && (w_alu_zi == r_si);
  assign w_snap      = is_pow2(32'(w_iter_nxt));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
      r_si <= '0;
    end else if (w_accept) begin
      r_sr <= '0;
      r_si <= '0;
    end else if (w_step && w_snap) begin
      r_sr <= w_alu_zr;
      r_si <= w_alu_zi;
    end
  end
`else
  assign w_cycle_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_load_out   = 1'b0;
    w_out_iter_d = '0;
    w_out_esc_d  = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          if (max_iter == '0) begin
            w_state_nxt = DONE;
            w_load_out  = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // Escape wins over the limit/cycle checks; z is left untouched.
        if (w_escape) begin
          w_state_nxt  = DONE;
          w_load_out   = 1'b1;
          w_out_iter_d = r_iter;
          w_out_esc_d  = 1'b1;
        end else begin
          w_step = 1'b1;
          if (w_iter_nxt == r_max || w_cycle_hit) begin
            w_state_nxt  = DONE;
            w_load_out   = 1'b1;
            w_out_iter_d = r_max;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_zr       <= '0;
      r_zi       <= '0;
      r_cr       <= '0;
      r_ci       <= '0;
      r_max      <= '0;
      r_iter     <= '0;
      r_out_iter <= '0;
      r_out_esc  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cr   <= in_cr;
        r_ci   <= in_ci;
        r_max  <= max_iter;
        r_zr   <= '0;
        r_zi   <= '0;
        r_iter <= '0;
      end
      if (w_step) begin
        r_zr   <= w_alu_zr;
        r_zi   <= w_alu_zi;
        r_iter <= w_iter_nxt;
      end
      if (w_load_out) begin
        r_out_iter <= w_out_iter_d;
        r_out_esc  <= w_out_esc_d;
      end
    end
  end

  assign out_iter    = r_out_iter;
  assign out_escaped = r_out_esc;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// tb_mandelbrot_iter_ctrl: directed and randomized checks of mandelbrot_iter_ctrl
// (WIDTH = 8, ITER_WIDTH = 8) against an integer-arithmetic reference model.
module tb_mandelbrot_iter_ctrl;
  import mandelbrot_pkg::*;

  localparam int W    = 8;
  localparam int IW   = 8;
  localparam int FRAC = W - 2;
  localparam int BUDGET = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_cr, in_ci;
  logic [IW-1:0] max_iter;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_iter;
  logic          out_escaped;

  int checks   = 0;
  int failures = 0;

  mandelbrot_iter_ctrl #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cr       (in_cr),
    .in_ci       (in_ci),
    .max_iter    (max_iter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped)
  );

  always #5 clk = ~clk;

  // Reference: iterate z <- z^2 + c on plain integers. k = RUN cycles used.
  task automatic model(input int cr, input int ci, input int mx,
                       output int iter, output int esc, output int k);
    int zr, zi, nr, ni, sr, si, nxt_snap;
    bit bad;
    zr = 0; zi = 0; sr = 0; si = 0; nxt_snap = 1;
    iter = mx; esc = 0; k = 0;
    for (int it = 0; it < mx; it++) begin
      k++;
      nr  = ((zr * zr - zi * zi) >>> FRAC) + cr;
      ni  = ((2 * zr * zi) >>> FRAC) + ci;
      bad = (zr * zr + zi * zi > 4 * FP_ONE * FP_ONE) ||
            nr > 127 || nr < -128 || ni > 127 || ni < -128;
      if (bad) begin
        iter = it; esc = 1;
        break;
      end
`ifdef MANDELBROT_CYCLE_DETECT_EN
      if (nr == sr && ni == si) break;
      if (it + 1 == nxt_snap) begin
        sr = nr; si = ni; nxt_snap = nxt_snap * 2;
      end
`endif
      zr = nr; zi = ni;
    end
  endtask

  // All drivers run in the posedge+1 phase.
  task automatic send(input int cr, input int ci, input int mx);
    in_cr    = cr[W-1:0];
    in_ci    = ci[W-1:0];
    max_iter = mx[IW-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cr    = W'($urandom);
    in_ci    = W'($urandom);
    max_iter = IW'($urandom);
  endtask

  // lat = cycles from the accept cycle to the first out_valid cycle.
  task automatic wait_out(output int lat, output bit timed_out);
    lat = 1; timed_out = 1'b0;
    while (out_valid !== 1'b1) begin
      if (lat >= BUDGET) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic recover();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_cr = '0; in_ci = '0; max_iter = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_iter !== '0 || out_escaped !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_iter=%0d esc=%b want 1 0 0 0",
               in_ready, out_valid, out_iter, out_escaped);
    end
  endtask

  task automatic test_directed(input string name, input int cr, input int ci,
                               input int mx, input int e_iter, input int e_esc,
                               input int e_lat);
    int lat; bit to;
    send(cr, ci, mx);
    wait_out(lat, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL %s_timeout: no out_valid within %0d cycles", name, BUDGET);
      recover();
      return;
    end
    checks++;
    if (lat != e_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, e_lat);
    end
    checks++;
    if (int'(out_iter) != e_iter || int'(out_escaped) != e_esc) begin
      failures++;
      $display("FAIL %s_result: iter=%0d esc=%b want iter=%0d esc=%0d",
               name, out_iter, out_escaped, e_iter, e_esc);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat; bit to; bit bad;
    send(FP_ONE + FP_ONE / 2, 0, 20);
    wait_out(lat, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL bp_timeout: no out_valid within %0d cycles", BUDGET);
      recover();
      return;
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_iter !== 8'd1 || out_escaped !== 1'b1 || in_ready !== 1'b0)
        bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: outputs moved under backpressure, now valid=%b iter=%0d esc=%b rdy=%b",
               out_valid, out_iter, out_escaped, in_ready);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    send(0, 0, 50);
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_running: out_valid=%b want 0", out_valid);
    end
    recover();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_iter !== '0 || out_escaped !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle: in_ready=%b out_valid=%b iter=%0d esc=%b want 1 0 0 0",
               in_ready, out_valid, out_iter, out_escaped);
    end
    seen = 1'b0;
    repeat (60) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midrst_no_result: out_valid seen=1 want 0");
    end
    test_directed("midrst_next", FP_ONE + FP_ONE / 2, 0, 20, 1, 1, 3);
  endtask

  task automatic test_random(input int n, input bit b2b);
    int cr, ci, mx, e_iter, e_esc, k, lat;
    bit to;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) begin
        cr = int'($urandom_range(255)) - 128;
        ci = int'($urandom_range(255)) - 128;
      end else begin
        cr = int'($urandom_range(80)) - 50;
        ci = int'($urandom_range(60)) - 30;
      end
      mx = (i % 7 == 0) ? int'($urandom_range(3)) : int'($urandom_range(60));
      model(cr, ci, mx, e_iter, e_esc, k);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rnd_ready[%0d]: in_ready=%b want 1", i, in_ready);
      end
      send(cr, ci, mx);
      wait_out(lat, to);
      checks++;
      if (to) begin
        failures++;
        $display("FAIL rnd_timeout[%0d]: c=(%0d,%0d) max=%0d", i, cr, ci, mx);
        recover();
        continue;
      end
      checks++;
      if (int'(out_iter) != e_iter || int'(out_escaped) != e_esc || lat != k + 1) begin
        failures++;
        $display("FAIL rnd[%0d]: c=(%0d,%0d) max=%0d got iter=%0d esc=%b lat=%0d want iter=%0d esc=%0d lat=%0d",
                 i, cr, ci, mx, out_iter, out_escaped, lat, e_iter, e_esc, k + 1);
      end
      if (!b2b) repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      consume();
    end
  endtask

  initial begin
    int zero_lat, cd_lat;
`ifdef MANDELBROT_CYCLE_DETECT_EN
    zero_lat = 2; cd_lat = 2;
`else
    zero_lat = 11; cd_lat = 61;
`endif
    test_reset();
    test_directed("origin10", 0, 0, 10, 10, 0, zero_lat);
    test_directed("overflow", FP_ONE + FP_ONE / 2, 0, 20, 1, 1, 3);
    test_directed("max_zero", int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 0, 0, 0, 1);
    test_backpressure();
    test_reset_mid_run();
    test_directed("origin60", 0, 0, 60, 60, 0, cd_lat);
    test_random(40, 1'b0);
    test_random(10, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
Sequential iteration engine for one Mandelbrot pixel. It accepts a point c = (cr, ci) via a valid/ready handshake and iterates z <- z^2 + c. Each cycle it uses one instance of the existing combinational step unit mandelbrot_alu. It stops on escape (size or overflow flag) or on reaching max_iter, then presents the iteration count downstream, e.g. to the colour mapper or pixel buffer.

Parameters:
- WIDTH, 8, fixed-point word width; format 2.(WIDTH-2), signed, so 1.0 = 1<<(WIDTH-2).
- ITER_WIDTH, 8, width of the iteration counter and of max_iter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  c point offered.
- in_ready  out  1  engine can accept c; high only in IDLE.
- in_cr  in  WIDTH  real part of c, signed 2.(WIDTH-2).
- in_ci  in  WIDTH  imaginary part of c, signed 2.(WIDTH-2).
- max_iter  in  ITER_WIDTH  iteration limit; sampled at accept.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  downstream accepts result.
- out_iter  out  ITER_WIDTH  completed iterations before escape, or max_iter if not escaped.
- out_escaped  out  1  1 = point escaped; 0 = limit reached (treated as inside).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset, effective mid-operation too: state = IDLE; zr, zi, cr, ci, iter, out_iter = 0; out_escaped = 0. Any in-flight point is discarded and no result is emitted.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch cr, ci and max_iter; set zr = zi = 0 and iter = 0.
  - If the latched max_iter == 0, go to DONE with out_iter = 0 and out_escaped = 0. Otherwise go to RUN.
- RUN, one iteration per cycle. The ALU is fed the registered zr, zi, cr, ci.
  - If ALU size | overflow: go to DONE with out_iter = iter and out_escaped = 1. The z registers are not updated.
  - Otherwise: zr <= alu out_zr, zi <= alu out_zi, iter <= iter + 1.
  - If iter + 1 == max_iter: go to DONE with out_iter = max_iter and out_escaped = 0.
  - The escape test takes priority over the limit test in the same cycle.
- DONE:
  - out_valid = 1; out_iter and out_escaped are held stable until the handshake.
  - On out_ready: go to IDLE. in_ready rises the following cycle, so there is no same-cycle turnaround.
- Latency: accept cycle, then k RUN cycles, then out_valid in the next cycle. k = escape iteration + 1, or max_iter.
- in_cr, in_ci and max_iter are ignored outside the IDLE accept cycle.
- The iteration counter never wraps, because max_iter is at most 2^ITER_WIDTH - 1.
- out_valid and in_ready are never high in the same cycle.

Optional Feature:
- Macro: MANDELBROT_CYCLE_DETECT_EN.
- Enabled: adds Brent-style periodicity detection.
  - Snapshot registers sr, si are set to 0 at accept.
  - In RUN, after computing the new z: if the new z equals (sr, si) and no escape occurs, go to DONE with out_iter = max_iter and out_escaped = 0.
  - When iter + 1 is a power of two, sr, si <= the new z.
- Disabled: no snapshot registers and no compare; behaviour exactly as above.
- Results for escaped points are identical in both builds. Only the latency of interior points differs.

Decomposition:
- Package mandelbrot_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the fixed-point constant FP_ONE = 1<<(WIDTH-2);
  - a helper function is_pow2 for the optional feature.
- One sub-module: the existing mandelbrot_alu, instantiated once with WIDTH passed through.
- The FSM, counter and registers stay in mandelbrot_iter_ctrl.

Test Plan (WIDTH = 8, 1.0 = 64):
- c = (0, 0), max_iter = 10, macro off -> out_iter = 10, out_escaped = 0, out_valid exactly 11 cycles after accept.
- c = (96, 0) (1.5), max_iter = 20 -> overflow at iter = 1, out_iter = 1, out_escaped = 1, out_valid 3 cycles after accept.
- max_iter = 0, any c -> out_iter = 0, out_escaped = 0, out_valid 1 cycle after accept, no RUN cycle.
- Result presented with out_ready held low for 5 cycles -> out_valid, out_iter and out_escaped stable; in_ready = 0 throughout; IDLE entered after out_ready is asserted.
- rst pulsed during RUN of c = (0, 0), max_iter = 50 -> next cycle: IDLE, in_ready = 1, out_valid = 0, no result emitted. A new point is then processed correctly.
- Macro on: c = (0, 0), max_iter = 60 -> out_iter = 60, out_escaped = 0, out_valid 2 cycles after accept. Macro off gives the same result with out_valid after 61 cycles.
